fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end.
- Replaces the separate program counter and instruction memory pair ahead of decode_block.
- Holds a loadable instruction memory and a fetch PC issuing one synchronous read per cycle, with a prefetch queue of QUEUE_DEPTH entries that absorbs decode stalls.
- Adds branch redirect with pipeline flush, and a load mode that restarts execution from RESET_PC.

Parameters:
- INSTR_WIDTH, 16, instruction width in bits (HALF_WORD).
- PC_WIDTH, 32, byte-address width (WORD).
- MEM_DEPTH, 256, instruction memory entries; power of 2.
- QUEUE_DEPTH, 4, prefetch queue entries; power of 2, >= 2.
- RESET_PC, 0, byte address fetched after reset or after load mode ends; bit 0 zero.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- program_mem_write_en_i  in  1  load mode; writes instruction_i to memory.
- instruction_i  in  INSTR_WIDTH  load-mode write data.
- instruction_addr_i  in  PC_WIDTH  load-mode byte address.
- redirect_valid_i  in  1  taken branch from a later stage.
- redirect_pc_i  in  PC_WIDTH  branch target byte address.
- stall_i  in  1  decode cannot accept this cycle.
- is_valid_o  out  1  instruction_o / program_counter_o valid.
- instruction_o  out  INSTR_WIDTH  queue head instruction.
- program_counter_o  out  PC_WIDTH  byte address of instruction_o.
- queue_count_o  out  $clog2(QUEUE_DEPTH+1)  occupied queue entries.

Behaviour:
- Reset (reset_i low, asynchronous):
  - fetch_pc = RESET_PC, state RUN, queue empty, no read in flight.
  - is_valid_o = 0, instruction_o = 0, program_counter_o = 0, queue_count_o = 0.
  - Memory contents are not reset.
- Memory:
  - Index = addr[$clog2(MEM_DEPTH):1]; bit 0 ignored; higher bits wrap modulo MEM_DEPTH.
  - Read is synchronous with 1-cycle latency. Write is synchronous.
- FSM, RUN:
  - Issue a read at fetch_pc when (count + inflight - pop) < QUEUE_DEPTH.
  - pop = is_valid_o && !stall_i.
  - On issue: fetch_pc += 2 and inflight is set. The returned data plus its PC are pushed the next cycle.
- FSM, LOAD: entered while program_mem_write_en_i = 1.
  - Each cycle writes instruction_i to mem[index(instruction_addr_i)].
  - No reads are issued, the queue is flushed, the in-flight read is discarded, and is_valid_o = 0.
  - LOAD -> RUN on the first cycle program_mem_write_en_i = 0: fetch_pc = RESET_PC, queue empty, then normal fetch.
- Output timing:
  - Show-ahead: outputs are driven from the queue head register.
  - instruction_o and program_counter_o are 0 whenever is_valid_o = 0.
  - The first instruction is valid after the 2nd rising edge following reset release or LOAD exit (no stall).
  - Sustained rate is 1 instruction/cycle with stall_i low.
- Stall:
  - Head is held, and outputs stay stable while stall_i = 1.
  - The queue fills to QUEUE_DEPTH, then fetch stops; no data is lost or duplicated.
  - The in-flight read always has a reserved slot.
- Redirect (RUN), sampled at edge N:
  - Queue cleared; in-flight read dropped (never pushed); fetch_pc = redirect_pc_i.
  - is_valid_o = 0 after edge N. The target instruction is valid after edge N+2.
  - redirect_pc_i bit 0 is cleared.
- Priority: reset > program_mem_write_en_i > redirect_valid_i > stall/pop.
  - Redirect with stall: the flush still occurs.
  - Push and pop in the same cycle: count unchanged.
- queue_count_o is registered and always equals the number of valid entries, 0..QUEUE_DEPTH.
- fetch_pc wraps modulo 2^PC_WIDTH.

Decomposition:
- Shared package (GENERAL_DEFS):
  - fetch_entry_t struct {pc PC_WIDTH, instr INSTR_WIDTH}.
  - fetch_state_e {FETCH_RUN, FETCH_LOAD}.
  - Existing HALF_WORD and WORD constants.
- Sub-module fetch_queue: parametrised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Flush takes priority over push and pop.
- Memory, fetch PC, FSM and read-credit logic stay in fetch_unit.

Test Plan:
- Load test: write 0x1111,0x2222,0x3333,0x4444 at addrs 0,2,4,6, then release load with stall_i = 0 -> outputs (pc,instr) = (0,1111),(2,2222),(4,3333),(6,4444) on consecutive cycles from the 2nd edge after release.
- Stall test: hold stall_i = 1 for 10 cycles mid-stream -> queue_count_o saturates at 4 and the head stays stable. On release, the sequence continues without gap, duplicate or skip.
- Redirect test: redirect_valid_i = 1 with pc 0x40 at edge N, while an entry is in flight -> is_valid_o = 0 after N. (0x40, mem[32]) is valid after N+2, and no pre-redirect instruction appears.
- Simultaneous events: redirect + stall at the same edge -> flush occurs. Redirect during load mode -> ignored; fetch restarts at RESET_PC.
- Reset test: assert reset_i low asynchronously mid-stream -> outputs are 0 immediately, before any clock edge. After release, fetch restarts at RESET_PC and memory contents are preserved.
- Wrap test: MEM_DEPTH = 256, fetch pc 0x1FE then 0x200 -> instr from mem[255], then mem[0]; program_counter_o = 0x200.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end: queue entry layout and fetch FSM states.
package fetch_unit_pkg;

  localparam int HALF_WORD = 16;
  localparam int WORD      = 32;

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [HALF_WORD-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_LOAD
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with show-ahead head; flush overrides push and pop.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: the count gates everything downstream.
  always_ff @(posedge clk_i) begin
    if (push && !flush) entries[wr_ptr] <= push_entry;
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: loadable instruction memory, fetch PC with read
// credits against the prefetch queue, branch redirect and load-mode restart.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 INSTR_WIDTH = HALF_WORD,
  parameter int                 PC_WIDTH    = WORD,
  parameter int                 MEM_DEPTH   = 256,
  parameter int                 QUEUE_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             program_mem_write_en_i,
  input  logic [INSTR_WIDTH-1:0]           instruction_i,
  input  logic [PC_WIDTH-1:0]              instruction_addr_i,
  input  logic                             redirect_valid_i,
  input  logic [PC_WIDTH-1:0]              redirect_pc_i,
  input  logic                             stall_i,
  output logic                             is_valid_o,
  output logic [INSTR_WIDTH-1:0]           instruction_o,
  output logic [PC_WIDTH-1:0]              program_counter_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, issue_pc, inflight_pc_q;
  logic inflight_q, inflight_d, issue, pop, flush;
  logic [CNT_W:0] credits;
  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];
  logic [INSTR_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0] count;
  fetch_entry_t push_entry, head;
  logic unused_bits;

  // The first fetch after load mode comes from RESET_PC regardless of fetch_pc.
  always_comb begin
    state_d    = program_mem_write_en_i ? FETCH_LOAD : FETCH_RUN;
    issue_pc   = (state_q == FETCH_LOAD) ? RESET_PC : fetch_pc_q;
    flush      = program_mem_write_en_i || redirect_valid_i;
    pop        = is_valid_o && !stall_i;
    credits    = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue      = 1'b0;
    inflight_d = 1'b0;
    fetch_pc_d = issue_pc;
    if (program_mem_write_en_i) begin
      fetch_pc_d = RESET_PC;
    end else if (redirect_valid_i) begin
      fetch_pc_d = {redirect_pc_i[PC_WIDTH-1:1], 1'b0};
    end else if (credits < (CNT_W+1)'(QUEUE_DEPTH)) begin
      issue      = 1'b1;
      inflight_d = 1'b1;
      fetch_pc_d = issue_pc + PC_WIDTH'(2);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= FETCH_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      if (issue) inflight_pc_q <= issue_pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (program_mem_write_en_i) mem[instruction_addr_i[MEM_AW:1]] <= instruction_i;
    if (issue) rdata_q <= mem[issue_pc[MEM_AW:1]];
  end

  assign push_entry.pc    = WORD'(inflight_pc_q);
  assign push_entry.instr = HALF_WORD'(rdata_q);

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push      (inflight_q),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign is_valid_o        = (count != '0);
  assign instruction_o     = is_valid_o ? INSTR_WIDTH'(head.instr) : '0;
  assign program_counter_o = is_valid_o ? PC_WIDTH'(head.pc) : '0;
  assign queue_count_o     = count;

  assign unused_bits = ^{instruction_addr_i[PC_WIDTH-1:MEM_AW+1], instruction_addr_i[0],
                         redirect_pc_i[0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: load, stall, redirect, wrap and async reset.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        program_mem_write_en_i;
  logic [15:0] instruction_i;
  logic [31:0] instruction_addr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        is_valid_o;
  logic [15:0] instruction_o;
  logic [31:0] program_counter_o;
  logic [2:0]  queue_count_o;

  logic [15:0] model_mem [256];
  exp_t        sb [$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] held_pc;
  logic [15:0] held_instr;

  fetch_unit dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .program_mem_write_en_i(program_mem_write_en_i),
    .instruction_i         (instruction_i),
    .instruction_addr_i    (instruction_addr_i),
    .redirect_valid_i      (redirect_valid_i),
    .redirect_pc_i         (redirect_pc_i),
    .stall_i               (stall_i),
    .is_valid_o            (is_valid_o),
    .instruction_o         (instruction_o),
    .program_counter_o     (program_counter_o),
    .queue_count_o         (queue_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [15:0] data,
                               input logic redir, input logic [31:0] rpc, input logic stall);
    program_mem_write_en_i = we;
    instruction_addr_i     = addr;
    instruction_i          = data;
    redirect_valid_i       = redir;
    redirect_pc_i          = rpc;
    stall_i                = stall;
  endtask

  function automatic void pushStream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(2 * i);
      sb.push_back('{pc, model_mem[pc[8:1]]});
    end
  endfunction

  // Whatever head is consumed at the coming edge must be the next scoreboard entry.
  task automatic step();
    exp_t e;
    if (reset_i && is_valid_o && !stall_i && !redirect_valid_i && !program_mem_write_en_i) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL sb_underrun: got pc 0x%0h, want no output", program_counter_o);
      end else begin
        e = sb.pop_front();
        checkOutput("seq_pc", 64'(program_counter_o), 64'(e.pc));
        checkOutput("seq_instr", 64'(instruction_o), 64'(e.instr));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 64'(is_valid_o), 64'd1);
    checkOutput({tag, "_pc"}, 64'(program_counter_o), 64'(pc));
    checkOutput({tag, "_instr"}, 64'(instruction_o), 64'(model_mem[pc[8:1]]));
  endtask

  // Redirect at the next edge, then confirm the two-edge bubble and target head.
  task automatic redirectTo(input string tag, input logic [31:0] target, input logic stall);
    logic [31:0] clean;
    clean = {target[31:1], 1'b0};
    sb.delete();
    pushStream(clean, 30);
    applyStimulus(1'b0, 32'd0, 16'd0, 1'b1, target, stall);
    step();
    checkOutput({tag, "_flush_valid"}, 64'(is_valid_o), 64'd0);
    checkOutput({tag, "_flush_count"}, 64'(queue_count_o), 64'd0);
    applyStimulus(1'b0, 32'd0, 16'd0, 1'b0, 32'd0, 1'b0);
    step();
    checkOutput({tag, "_n1_valid"}, 64'(is_valid_o), 64'd0);
    step();
    checkHead({tag, "_n2"}, clean);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      model_mem[i] = (i < 4) ? 16'(16'h1111 * (i + 1)) : (16'h5A00 ^ 16'(i));

    reset_i = 1'b0;
    applyStimulus(1'b1, 32'd0, model_mem[0], 1'b0, 32'd0, 1'b0);
    #1;
    checkOutput("reset_valid", 64'(is_valid_o), 64'd0);
    checkOutput("reset_instr", 64'(instruction_o), 64'd0);
    checkOutput("reset_pc", 64'(program_counter_o), 64'd0);
    checkOutput("reset_count", 64'(queue_count_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;

    // Load the whole memory; a redirect mid-load must be ignored.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 32'(2 * i), model_mem[i], (i == 100), 32'h0000_0080, 1'b0);
      step();
      if (i == 100) checkOutput("load_valid", 64'(is_valid_o), 64'd0);
    end

    applyStimulus(1'b0, 32'd0, 16'd0, 1'b0, 32'd0, 1'b0);
    sb.delete();
    pushStream(32'd0, 40);
    step();
    checkOutput("load_exit_e1_valid", 64'(is_valid_o), 64'd0);
    step();
    checkHead("load_exit_e2", 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      checkHead("load_stream", 32'(2 * i));
    end
    for (int i = 0; i < 3; i++) step();

    held_pc    = program_counter_o;
    held_instr = instruction_o;
    applyStimulus(1'b0, 32'd0, 16'd0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("stall_hold_pc", 64'(program_counter_o), 64'(held_pc));
      checkOutput("stall_hold_instr", 64'(instruction_o), 64'(held_instr));
    end
    checkOutput("stall_count_full", 64'(queue_count_o), 64'd4);
    applyStimulus(1'b0, 32'd0, 16'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("stall_release_valid", 64'(is_valid_o), 64'd1);
    end

    redirectTo("redirect", 32'h0000_0041, 1'b0);
    for (int i = 0; i < 5; i++) step();

    redirectTo("redirect_stall", 32'h0000_0080, 1'b1);
    for (int i = 0; i < 3; i++) step();

    redirectTo("wrap", 32'h0000_01FE, 1'b0);
    step();
    checkHead("wrap_next", 32'h0000_0200);
    for (int i = 0; i < 3; i++) step();

    #3;
    reset_i = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(is_valid_o), 64'd0);
    checkOutput("async_reset_instr", 64'(instruction_o), 64'd0);
    checkOutput("async_reset_pc", 64'(program_counter_o), 64'd0);
    checkOutput("async_reset_count", 64'(queue_count_o), 64'd0);
    step();
    step();
    reset_i = 1'b1;
    sb.delete();
    pushStream(32'd0, 20);
    step();
    checkOutput("post_reset_e1_valid", 64'(is_valid_o), 64'd0);
    step();
    checkHead("post_reset_e2", 32'd0);
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
